// File: rtl/sdram_write_buffer_if.sv
// Byte-in / burst-out bus between the avionics data path, the write buffer and the
// SDRAM controller. Optional macro DROP_COUNT_EN adds the drop_count signal.
interface sdram_write_buffer_if #(
    parameter int unsigned FIFO_AW = 5,
    parameter int unsigned ADDR_W  = 24
);
    logic [7:0]        data_in;
    logic              data_valid;
    logic              flush;
    logic              full;
    logic              wr_req;
    logic              wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              burst_done;
    logic [FIFO_AW:0]  word_count;
`ifdef DROP_COUNT_EN
    logic [15:0]       drop_count;

    modport slave (
        input  data_in, data_valid, flush, wr_ack,
        output full, wr_req, wr_addr, wr_data, burst_done, word_count, drop_count
    );
    modport master (
        output data_in, data_valid, flush, wr_ack,
        input  full, wr_req, wr_addr, wr_data, burst_done, word_count, drop_count
    );
`else
    modport slave (
        input  data_in, data_valid, flush, wr_ack,
        output full, wr_req, wr_addr, wr_data, burst_done, word_count
    );
    modport master (
        output data_in, data_valid, flush, wr_ack,
        input  full, wr_req, wr_addr, wr_data, burst_done, word_count
    );
`endif
endinterface

// File: rtl/sdram_write_buffer.sv
// Packs a byte stream into 16-bit words, buffers them in a FIFO and issues fixed-length
// REQ/ACK write bursts to the SDRAM controller. Optional macro DROP_COUNT_EN.
module sdram_write_buffer #(
    parameter int unsigned        FIFO_AW   = 5,
    parameter int unsigned        BURST_LEN = 8,
    parameter int unsigned        ADDR_W    = 24,
    parameter logic [ADDR_W-1:0]  ADDR_MAX  = {ADDR_W{1'b1}}
) (
    input  logic                 clk_48mhz,
    input  logic                 reset,
    sdram_write_buffer_if.slave  bus
);
    localparam int unsigned      DEPTH_N = 2 ** FIFO_AW;
    localparam int unsigned      BEAT_W  = $clog2(BURST_LEN) + 1;
    localparam logic [FIFO_AW:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] BURST_CNT = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] ONE_WORD  = (FIFO_AW + 1)'(1);
    localparam logic [BEAT_W-1:0] BEAT_INIT = BEAT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain, StDone} state_t;

    logic [15:0]       mem [DEPTH_N];
    logic [FIFO_AW:0]  wptr_q, rptr_q, wptr_d, rptr_d, count;
    logic [15:0]       head_q, head_d;
    logic              have_low_q, have_low_d;
    logic [7:0]        low_q, low_d;
    logic              pad_q, pad_d;
    logic              flush_pend_q;
    logic              full, accept, push, pop;
    logic [15:0]       push_data;
    state_t            state_q;
    logic              wr_req_q;
    logic              burst_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BEAT_W-1:0] beat_q;

    // Packer: a pending flush pad takes the push slot ahead of any new byte pair.
    always_comb begin
        count      = wptr_q - rptr_q;
        full       = (count == DEPTH);
        accept     = bus.data_valid && !full;
        push       = 1'b0;
        push_data  = {bus.data_in, low_q};
        have_low_d = have_low_q;
        low_d      = low_q;
        pad_d      = pad_q;
        if (pad_q && !full) begin
            push       = 1'b1;
            push_data  = {8'h00, low_q};
            pad_d      = 1'b0;
            have_low_d = accept;
            if (accept) begin
                low_d = bus.data_in;
            end
        end else if (accept) begin
            if (have_low_q) begin
                push       = 1'b1;
                have_low_d = 1'b0;
            end else begin
                low_d      = bus.data_in;
                have_low_d = 1'b1;
            end
        end
        if (bus.flush && have_low_d) begin
            pad_d = 1'b1;
        end
    end

    always_comb begin
        pop    = wr_req_q && bus.wr_ack;
        wptr_d = wptr_q + {{FIFO_AW{1'b0}}, push};
        rptr_d = rptr_q + {{FIFO_AW{1'b0}}, pop};
        // Bypass the word being written when it becomes the new head.
        if (push && (wptr_q == rptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem[rptr_d[FIFO_AW-1:0]];
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (push) begin
            mem[wptr_q[FIFO_AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            head_q       <= '0;
            have_low_q   <= 1'b0;
            low_q        <= '0;
            pad_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            state_q      <= StIdle;
            wr_req_q     <= 1'b0;
            burst_done_q <= 1'b0;
            addr_q       <= '0;
            beat_q       <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            head_q       <= head_d;
            have_low_q   <= have_low_d;
            low_q        <= low_d;
            pad_q        <= pad_d;
            burst_done_q <= 1'b0;
            if (pop) begin
                addr_q <= (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (count >= BURST_CNT) begin
                        state_q  <= StBurst;
                        wr_req_q <= 1'b1;
                        beat_q   <= BEAT_INIT;
                    end else if (flush_pend_q && !pad_q && count != '0) begin
                        state_q  <= StDrain;
                        wr_req_q <= 1'b1;
                        beat_q   <= BEAT_INIT;
                    end else if (flush_pend_q && !pad_q && !push) begin
                        flush_pend_q <= 1'b0;
                    end
                end
                StBurst: begin
                    if (bus.wr_ack) begin
                        beat_q <= beat_q - BEAT_ONE;
                        if (beat_q == BEAT_ONE) begin
                            state_q      <= StDone;
                            wr_req_q     <= 1'b0;
                            burst_done_q <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (bus.wr_ack) begin
                        beat_q <= beat_q - BEAT_ONE;
                        if (beat_q == BEAT_ONE || (count == ONE_WORD && !push)) begin
                            state_q      <= StDone;
                            wr_req_q     <= 1'b0;
                            burst_done_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    if (count == '0 && !pad_q && !push) begin
                        flush_pend_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // A new flush request always wins over any clear above.
            if (bus.flush) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

`ifdef DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (bus.data_valid && full && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.drop_count = drop_q;
`endif

    assign bus.full       = full;
    assign bus.wr_req     = wr_req_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = head_q;
    assign bus.burst_done = burst_done_q;
    assign bus.word_count = count;
endmodule

// File: tb/tb_sdram_write_buffer.sv
// Directed bench for sdram_write_buffer: packing, bursts, flush drain, overflow,
// address wrap (second instance with a small ADDR_MAX), ACK gaps and mid-burst reset.
module tb_sdram_write_buffer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done;
    logic [23:0] obs_addr [64];
    logic [15:0] obs_data [64];

    always #5 clk = ~clk;

    sdram_write_buffer_if #(.FIFO_AW(5), .ADDR_W(24)) bus ();
    sdram_write_buffer_if #(.FIFO_AW(5), .ADDR_W(24)) busw ();

    sdram_write_buffer #(
        .FIFO_AW(5), .BURST_LEN(8), .ADDR_W(24), .ADDR_MAX(24'hFFFFFF)
    ) dut (
        .clk_48mhz(clk), .reset(reset), .bus(bus)
    );

    sdram_write_buffer #(
        .FIFO_AW(5), .BURST_LEN(8), .ADDR_W(24), .ADDR_MAX(24'd11)
    ) dut_wrap (
        .clk_48mhz(clk), .reset(reset), .bus(busw)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.data_valid = 1'b0; bus.flush = 1'b0; bus.wr_ack = 1'b0; bus.data_in = '0;
        busw.data_valid = 1'b0; busw.flush = 1'b0; busw.wr_ack = 1'b0; busw.data_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.data_valid = 1'b1;
            bus.data_in    = first + 8'(i);
        end
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    // ACK every WR_REQ cycle, recording each accepted word and BURST_DONE pulses.
    task automatic run_acks(input int nwords, input int budget, output bit tmo);
        int got = 0;
        int cyc = 0;
        n_done = 0;
        while (got < nwords && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.wr_ack = 1'b0;
            if (bus.burst_done) n_done++;
            if (bus.wr_req) begin
                obs_addr[got] = bus.wr_addr;
                obs_data[got] = bus.wr_data;
                bus.wr_ack    = 1'b1;
                got++;
            end
        end
        tmo = (got < nwords);
        @(negedge clk);
        bus.wr_ack = 1'b0;
        if (bus.burst_done) n_done++;
        repeat (3) begin
            @(negedge clk);
            if (bus.burst_done) n_done++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.wr_req !== 1'b0) begin n_fail++;
            $display("FAIL reset_wr_req: got %0h want 0", bus.wr_req); end
        n_checks++; if (bus.wr_addr !== 24'h0) begin n_fail++;
            $display("FAIL reset_wr_addr: got %0h want 0", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 16'h0) begin n_fail++;
            $display("FAIL reset_wr_data: got %0h want 0", bus.wr_data); end
        n_checks++; if (bus.burst_done !== 1'b0) begin n_fail++;
            $display("FAIL reset_burst_done: got %0h want 0", bus.burst_done); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++;
            $display("FAIL reset_full: got %0h want 0", bus.full); end
        n_checks++; if (bus.word_count !== 6'd0) begin n_fail++;
            $display("FAIL reset_word_count: got %0d want 0", bus.word_count); end
`ifdef DROP_COUNT_EN
        n_checks++; if (bus.drop_count !== 16'd0) begin n_fail++;
            $display("FAIL reset_drop_count: got %0d want 0", bus.drop_count); end
`endif
        apply_reset();
    endtask

    task automatic test_burst();
        bit tmo;
        logic [15:0] exp;
        apply_reset();
        send_seq(8'h00, 16);
        run_acks(8, 100, tmo);
        n_checks++; if (tmo) begin n_fail++;
            $display("FAIL burst_timeout: got fewer than 8 words want 8"); end
        for (int i = 0; i < 8; i++) begin
            exp = {8'(2 * i + 1), 8'(2 * i)};
            n_checks++; if (obs_addr[i] !== 24'(i)) begin n_fail++;
                $display("FAIL burst_addr[%0d]: got %0h want %0h", i, obs_addr[i], i); end
            n_checks++; if (obs_data[i] !== exp) begin n_fail++;
                $display("FAIL burst_data[%0d]: got %0h want %0h", i, obs_data[i], exp); end
        end
        n_checks++; if (n_done != 1) begin n_fail++;
            $display("FAIL burst_done_pulses: got %0d want 1", n_done); end
        n_checks++; if (bus.word_count !== 6'd0) begin n_fail++;
            $display("FAIL burst_word_count: got %0d want 0", bus.word_count); end
    endtask

    task automatic test_flush_drain();
        bit tmo;
        int req_cycles = 0;
        logic [15:0] exp [3];
        exp[0] = 16'hA2A1; exp[1] = 16'hA4A3; exp[2] = 16'h00A5;
        apply_reset();
        send_seq(8'hA1, 5);
        pulse_flush();
        run_acks(3, 50, tmo);
        n_checks++; if (tmo) begin n_fail++;
            $display("FAIL drain_timeout: got fewer than 3 words want 3"); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (obs_addr[i] !== 24'(i)) begin n_fail++;
                $display("FAIL drain_addr[%0d]: got %0h want %0h", i, obs_addr[i], i); end
            n_checks++; if (obs_data[i] !== exp[i]) begin n_fail++;
                $display("FAIL drain_data[%0d]: got %0h want %0h", i, obs_data[i], exp[i]); end
        end
        n_checks++; if (n_done != 1) begin n_fail++;
            $display("FAIL drain_done_pulses: got %0d want 1", n_done); end
        repeat (6) begin
            @(negedge clk);
            if (bus.wr_req) req_cycles++;
        end
        n_checks++; if (req_cycles != 0) begin n_fail++;
            $display("FAIL drain_idle_req: got %0d req cycles want 0", req_cycles); end
    endtask

    task automatic test_full_drop();
        bit tmo;
        logic [15:0] exp;
        apply_reset();
        send_seq(8'h00, 64);
        n_checks++; if (bus.full !== 1'b1) begin n_fail++;
            $display("FAIL full_flag: got %0h want 1", bus.full); end
        n_checks++; if (bus.word_count !== 6'd32) begin n_fail++;
            $display("FAIL full_count: got %0d want 32", bus.word_count); end
        send_seq(8'h40, 2);
        n_checks++; if (bus.word_count !== 6'd32) begin n_fail++;
            $display("FAIL full_count_after_drop: got %0d want 32", bus.word_count); end
`ifdef DROP_COUNT_EN
        n_checks++; if (bus.drop_count !== 16'd2) begin n_fail++;
            $display("FAIL drop_count: got %0d want 2", bus.drop_count); end
`endif
        run_acks(32, 300, tmo);
        n_checks++; if (tmo) begin n_fail++;
            $display("FAIL full_drain_timeout: got fewer than 32 words want 32"); end
        for (int i = 0; i < 32; i++) begin
            exp = {8'(2 * i + 1), 8'(2 * i)};
            n_checks++; if (obs_data[i] !== exp) begin n_fail++;
                $display("FAIL full_data[%0d]: got %0h want %0h", i, obs_data[i], exp); end
        end
        n_checks++; if (n_done != 4) begin n_fail++;
            $display("FAIL full_done_pulses: got %0d want 4", n_done); end
        // Dropped bytes must not have shifted the packer phase.
        send_seq(8'h77, 2);
        bus.data_in = 8'h88;
        @(negedge clk); bus.data_valid = 1'b1; bus.data_in = 8'h88;
        @(negedge clk); bus.data_valid = 1'b0;
        pulse_flush();
        run_acks(2, 50, tmo);
        n_checks++; if (tmo) begin n_fail++;
            $display("FAIL phase_timeout: got fewer than 2 words want 2"); end
        n_checks++; if (obs_data[0] !== 16'h7877) begin n_fail++;
            $display("FAIL phase_word0: got %0h want 7877", obs_data[0]); end
        n_checks++; if (obs_data[1] !== 16'h0088) begin n_fail++;
            $display("FAIL phase_word1: got %0h want 0088", obs_data[1]); end
        n_checks++; if (obs_addr[0] !== 24'd32) begin n_fail++;
            $display("FAIL phase_addr: got %0h want 20", obs_addr[0]); end
    endtask

    task automatic test_addr_wrap();
        int got = 0;
        int cyc = 0;
        logic [23:0] ea;
        logic [15:0] ed;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            busw.data_valid = 1'b1;
            busw.data_in    = 8'(i);
        end
        @(negedge clk);
        busw.data_valid = 1'b0;
        while (got < 16 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            busw.wr_ack = 1'b0;
            if (busw.wr_req) begin
                ea = (got < 12) ? 24'(got) : 24'(got - 12);
                ed = {8'(2 * got + 1), 8'(2 * got)};
                n_checks++; if (busw.wr_addr !== ea) begin n_fail++;
                    $display("FAIL wrap_addr[%0d]: got %0h want %0h", got, busw.wr_addr, ea); end
                n_checks++; if (busw.wr_data !== ed) begin n_fail++;
                    $display("FAIL wrap_data[%0d]: got %0h want %0h", got, busw.wr_data, ed); end
                busw.wr_ack = 1'b1;
                got++;
            end
        end
        @(negedge clk);
        busw.wr_ack = 1'b0;
        n_checks++; if (got != 16) begin n_fail++;
            $display("FAIL wrap_words: got %0d want 16", got); end
    endtask

    task automatic test_ack_gaps();
        int k = 0;
        int phase = 0;
        int cyc = 0;
        logic [15:0] ed;
        apply_reset();
        send_seq(8'h00, 20);
        n_done = 0;
        while (k < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.wr_ack = 1'b0;
            if (bus.wr_req) begin
                ed = {8'(2 * k + 1), 8'(2 * k)};
                n_checks++; if (bus.wr_addr !== 24'(k)) begin n_fail++;
                    $display("FAIL gap_addr[%0d]: got %0h want %0h", k, bus.wr_addr, k); end
                n_checks++; if (bus.wr_data !== ed) begin n_fail++;
                    $display("FAIL gap_data[%0d]: got %0h want %0h", k, bus.wr_data, ed); end
                if (phase == 2) begin
                    bus.wr_ack = 1'b1;
                    k++;
                    phase = 0;
                end else begin
                    phase++;
                end
            end
        end
        repeat (4) begin
            @(negedge clk);
            bus.wr_ack = 1'b0;
            if (bus.burst_done) n_done++;
        end
        n_checks++; if (k != 8) begin n_fail++;
            $display("FAIL gap_acks: got %0d want 8", k); end
        n_checks++; if (n_done != 1) begin n_fail++;
            $display("FAIL gap_done_pulses: got %0d want 1", n_done); end
        n_checks++; if (bus.word_count !== 6'd2) begin n_fail++;
            $display("FAIL gap_word_count: got %0d want 2", bus.word_count); end
        n_checks++; if (bus.wr_req !== 1'b0) begin n_fail++;
            $display("FAIL gap_req_after: got %0h want 0", bus.wr_req); end
    endtask

    task automatic test_reset_midburst();
        int acks = 0;
        int cyc = 0;
        int req_cycles = 0;
        bit seen = 1'b0;
        apply_reset();
        send_seq(8'h00, 16);
        while (acks < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.wr_ack = 1'b0;
            if (bus.wr_req) begin
                bus.wr_ack = 1'b1;
                acks++;
                if (acks == 4) reset = 1'b1;
            end
        end
        #1;
        n_checks++; if (bus.wr_req !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_wr_req: got %0h want 0", bus.wr_req); end
        n_checks++; if (bus.wr_addr !== 24'h0) begin n_fail++;
            $display("FAIL mid_rst_wr_addr: got %0h want 0", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 16'h0) begin n_fail++;
            $display("FAIL mid_rst_wr_data: got %0h want 0", bus.wr_data); end
        n_checks++; if (bus.word_count !== 6'd0) begin n_fail++;
            $display("FAIL mid_rst_word_count: got %0d want 0", bus.word_count); end
        n_checks++; if (bus.burst_done !== 1'b0 || bus.full !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_done_full: got %0h%0h want 00", bus.burst_done, bus.full); end
        @(negedge clk);
        bus.wr_ack = 1'b0;
        reset = 1'b0;
        send_seq(8'h50, 14);
        repeat (5) begin
            @(negedge clk);
            if (bus.wr_req) req_cycles++;
        end
        n_checks++; if (req_cycles != 0) begin n_fail++;
            $display("FAIL mid_rst_early_req: got %0d req cycles want 0", req_cycles); end
        send_seq(8'h5E, 2);
        cyc = 0;
        while (!seen && cyc < 10) begin
            if (bus.wr_req) seen = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        n_checks++; if (!seen) begin n_fail++;
            $display("FAIL mid_rst_new_burst: got no wr_req want wr_req"); end
        n_checks++; if (bus.wr_addr !== 24'h0 || bus.wr_data !== 16'h5150) begin n_fail++;
            $display("FAIL mid_rst_first_word: got %0h/%0h want 0/5150",
                     bus.wr_addr, bus.wr_data); end
    endtask

    initial begin
        reset = 1'b1;
        bus.data_valid = 1'b0; bus.flush = 1'b0; bus.wr_ack = 1'b0; bus.data_in = '0;
        busw.data_valid = 1'b0; busw.flush = 1'b0; busw.wr_ack = 1'b0; busw.data_in = '0;
        test_reset();
        test_burst();
        test_flush_drain();
        test_full_drop();
        test_addr_wrap();
        test_ack_gaps();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_write_buffer.md
Name: sdram_write_buffer

Overview:
Upstream feeder for the SDRAM controller/test stage. It accepts a byte stream from the avionics data path and packs byte pairs into 16-bit words. Words are buffered in an internal FIFO and issued to the SDRAM controller as fixed-length write bursts over a REQ/ACK handshake, with a linearly incrementing, wrapping SDRAM word address. Runs in the 48 MHz system domain.

Parameters:
FIFO_AW, 5, FIFO address width; depth = 2**FIFO_AW words (default 32)
BURST_LEN, 8, words per write burst; power of 2, <= 2**(FIFO_AW-1)
ADDR_W, 24, SDRAM word address width (2 bank + 13 row + 9 col)
ADDR_MAX, 24'hFFFFFF, last valid word address; the address wraps to 0 after it

Ports:
CLK_48MHZ  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
DATA_IN  in  8  input byte
DATA_VALID  in  1  DATA_IN is valid this cycle
FLUSH  in  1  one-cycle pulse: pad and drain all buffered data
FULL  out  1  FIFO cannot accept another word; bytes offered while FULL are dropped
WR_REQ  out  1  burst write request to the SDRAM controller
WR_ACK  in  1  controller accepted the current word (one pulse per word)
WR_ADDR  out  ADDR_W  word address of the current word
WR_DATA  out  16  current word
BURST_DONE  out  1  one-cycle pulse after the last ACK of a burst or flush drain
WORD_COUNT  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (async, active-high):
  - Outputs: WR_REQ=0, WR_ADDR=0, WR_DATA=0, BURST_DONE=0, FULL=0, WORD_COUNT=0.
  - Internal: FIFO pointers=0, packer empty, FSM=IDLE.
- Reset asserted mid-burst aborts the burst immediately and discards buffered data. No recovery of the partial burst.
- Packer:
  - The first byte of a pair is latched as low byte [7:0].
  - The second byte forms {DATA_IN, low} and is pushed the same cycle.
  - A byte is dropped whenever FULL=1 at the time it is offered. The packer phase does not advance on a dropped byte.
- FIFO:
  - Synchronous write, registered read. Pointers are FIFO_AW+1 bits for full/empty distinction.
  - FULL = (WORD_COUNT == 2**FIFO_AW).
  - Simultaneous push and pop leaves WORD_COUNT unchanged.
  - WR_DATA always presents the FIFO head word.
- FSM states:
  - IDLE:
    - Go to BURST when WORD_COUNT >= BURST_LEN. Load beat counter = BURST_LEN.
    - Else, if flush_pending and WORD_COUNT > 0, go to DRAIN.
    - Else, if flush_pending and WORD_COUNT == 0, clear flush_pending and stay in IDLE.
  - BURST:
    - WR_REQ=1.
    - On each WR_ACK: pop, WR_ADDR increments, beat counter decrements.
    - On the ACK with beat counter == 1: go to DONE.
  - DRAIN:
    - WR_REQ=1, pop per ACK as in BURST.
    - On the ACK that empties the FIFO, or at the BURST_LEN-th ACK, go to DONE.
  - DONE:
    - BURST_DONE=1 for 1 cycle, WR_REQ=0, then return to IDLE.
    - flush_pending is cleared here only if the FIFO is empty.
- Handshake rules:
  - WR_ADDR and WR_DATA are stable while WR_REQ=1 and no ACK occurs.
  - The next word is valid in the cycle after an ACK.
  - WR_ACK while WR_REQ=0 is ignored.
  - WR_REQ drops at least 1 cycle (the DONE state) between bursts.
- Address:
  - WR_ADDR increments by 1 per ACK.
  - At ADDR_MAX it wraps to 0 on the next ACK.
  - No modulo of any other address is performed.
- FLUSH:
  - Sets flush_pending.
  - If the packer holds a low byte, the word {8'h00, low} is pushed on the next cycle. If FULL, the push is delayed until space is available.
  - FLUSH coincident with DATA_VALID: the byte is packed first, then the pad is applied.
  - FLUSH during BURST: the burst completes, then the FSM enters DRAIN.

Optional Feature:
DROP_COUNT_EN:
- Defined: adds output DROP_COUNT[15:0], a saturating count of bytes dropped while FULL. Reset value 0. It holds at 16'hFFFF.
- Undefined: the port is absent and the dropped-byte logic is removed.

Test Plan:
- Reset then 16 bytes 8'h00..8'h0F at DATA_VALID=1, ACK every cycle of WR_REQ -> 8 ACKs. Words 16'h0100, 16'h0302 .. 16'h0F0E at WR_ADDR 0..7. BURST_DONE pulses once. WORD_COUNT=0.
- 5 bytes 8'hA1..8'hA5 then FLUSH -> DRAIN of 3 words 16'hA2A1, 16'hA4A3, 16'h00A5 at WR_ADDR 0..2. BURST_DONE once, then IDLE.
- Fill 64+2 bytes with WR_ACK held 0 -> FULL=1 at WORD_COUNT=32. The last 2 bytes are dropped (DROP_COUNT=2 with DROP_COUNT_EN). The FIFO content is unchanged.
- Preset address to ADDR_MAX-3 via 2**24-4 prior ACKed words (or force), then one burst -> WR_ADDR sequence FFFFFC..FFFFFF, 0, 1, 2, 3.
- ACK with 2-cycle gaps during a burst -> WR_ADDR and WR_DATA are held stable between ACKs. Exactly 8 pops occur.
- Assert RESET on the 4th ACK of a burst -> all outputs return to reset values at once. WORD_COUNT=0. No further WR_REQ until 8 new words have been written.
